serial_byte_tx: RTL and testbench

SERIAL_BYTE_TX -- requirements
Module: serial_byte_tx

---
 rtl/serial_byte_tx.sv | 183 ++++++++++++++++++
 tb/tb_serial_byte_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/serial_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_tx
// Description : Parallel-to-serial frame transmitter. A word accepted on the
//               tx_valid/tx_ready handshake is sent as a start bit (0), the
//               NUM_BITS data bits (MSB or LSB first), an optional even-parity
//               bit and a stop bit (1). Every bit lasts BIT_PERIOD clocks.
//               The line idles at 1.
// Ports       : clk        - system clock, rising edge
//               n_rst      - asynchronous active-low reset
//               tx_valid   - tx_data holds a word to send
//               tx_data    - parallel word to serialize
//               tx_ready   - word accepted this cycle (high only in IDLE)
//               serial_out - registered serial line, idle level 1
//               tx_busy    - a frame is in progress
//               tx_done    - one-cycle pulse on the last clock of STOP
// Options     : define SERIAL_BYTE_TX_PARITY_EN to add an even-parity bit
//               after the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_tx #(
  parameter int NUM_BITS   = 8,
  parameter int BIT_PERIOD = 10,
  parameter int SHIFT_MSB  = 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                tx_ready,
  output logic                serial_out,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int BW = $clog2(BIT_PERIOD);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [BW-1:0] c_bit_last  = BW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] c_data_last = CW'(NUM_BITS - 1);

`ifdef SERIAL_BYTE_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [BW-1:0]       r_bit_cnt;
  logic [CW-1:0]       r_data_cnt;
  logic [NUM_BITS-1:0] r_shift;
  logic [NUM_BITS-1:0] w_shift_next;
  logic                r_serial;
  logic                w_serial_next;
  logic                w_bit_last;
  logic                w_data_last;
  logic                w_parity;

  assign w_bit_last  = (r_bit_cnt == c_bit_last);
  assign w_data_last = (r_data_cnt == c_data_last);

`ifdef SERIAL_BYTE_TX_PARITY_EN
  // Parity is captured with the word since the shift register is consumed
  // while the data bits go out.
  logic r_parity;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_parity <= 1'b0;
    end else if (r_state == IDLE && tx_valid) begin
      r_parity <= ^tx_data;
    end
  end

  assign w_parity = r_parity;
`else
  assign w_parity = 1'b1;
`endif

  // Next state, next shift-register contents and the value serial_out takes
  // after the edge. serial_out is decoded from the *next* state so the
  // registered line lines up with the state it belongs to.
  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_serial_next = 1'b1;

    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_state_next = START;
          w_shift_next = tx_data;
        end
      end
      START: begin
        if (w_bit_last) w_state_next = DATA;
      end
      DATA: begin
        if (w_bit_last) begin
          // Vacated positions fill with 1 so the register returns to idle.
          w_shift_next = (SHIFT_MSB != 0) ? {r_shift[NUM_BITS-2:0], 1'b1}
                                          : {1'b1, r_shift[NUM_BITS-1:1]};
          if (w_data_last) begin
`ifdef SERIAL_BYTE_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_BYTE_TX_PARITY_EN
      PARITY: begin
        if (w_bit_last) w_state_next = STOP;
      end
`endif
      STOP: begin
        if (w_bit_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase

    case (w_state_next)
      START:   w_serial_next = 1'b0;
      DATA:    w_serial_next = (SHIFT_MSB != 0) ? w_shift_next[NUM_BITS-1]
                                                : w_shift_next[0];
`ifdef SERIAL_BYTE_TX_PARITY_EN
      PARITY:  w_serial_next = w_parity;
`endif
      default: w_serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_shift    <= '1;
      r_serial   <= 1'b1;
      r_bit_cnt  <= '0;
      r_data_cnt <= '0;
    end else begin
      r_state  <= w_state_next;
      r_shift  <= w_shift_next;
      r_serial <= w_serial_next;

      // Bit-period counter restarts on every state entry and on every bit
      // boundary inside DATA; it stays at 0 while idle.
      if (w_state_next != r_state || w_bit_last) begin
        r_bit_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end

      if (w_state_next != r_state) begin
        r_data_cnt <= '0;
      end else if (r_state == DATA && w_bit_last) begin
        r_data_cnt <= r_data_cnt + CW'(1);
      end
    end
  end

  assign serial_out = r_serial;
  assign tx_ready   = (r_state == IDLE);
  assign tx_busy    = (r_state != IDLE);
  assign tx_done    = (r_state == STOP) && w_bit_last;

  // Keeps the parity wire referenced in builds without the parity bit.
  logic w_unused;
  assign w_unused = w_parity;

endmodule
`default_nettype wire

// File: tb/tb_serial_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_byte_tx
// Description : Directed self-checking bench for serial_byte_tx with
//               NUM_BITS=8, BIT_PERIOD=4. One instance sends MSB first, a
//               second sends LSB first. Expected line values come from the
//               frame layout and hand-computed parity constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_byte_tx;

  localparam int NB = 8;
  localparam int BP = 4;
`ifdef SERIAL_BYTE_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = (2 + NB + PB) * BP;

  logic          clk;
  logic          n_rst;
  logic          valid_m, valid_l;
  logic [NB-1:0] data_m, data_l;
  logic          ready_m, so_m, busy_m, done_m;
  logic          ready_l, so_l, busy_l, done_l;

  int n_checks = 0;
  int n_fail   = 0;

  serial_byte_tx #(.NUM_BITS(NB), .BIT_PERIOD(BP), .SHIFT_MSB(1)) dut_msb (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_valid   (valid_m),
    .tx_data    (data_m),
    .tx_ready   (ready_m),
    .serial_out (so_m),
    .tx_busy    (busy_m),
    .tx_done    (done_m)
  );

  serial_byte_tx #(.NUM_BITS(NB), .BIT_PERIOD(BP), .SHIFT_MSB(0)) dut_lsb (
    .clk        (clk),
    .n_rst      (n_rst),
    .tx_valid   (valid_l),
    .tx_data    (data_l),
    .tx_ready   (ready_l),
    .serial_out (so_l),
    .tx_busy    (busy_l),
    .tx_done    (done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a word from a falling edge; returns 1 time unit after the
  // handshake edge, which is frame clock 1.
  task automatic handshake(input bit lsb, input logic [NB-1:0] d);
    if (lsb) begin valid_l = 1'b1; data_l = d; end
    else     begin valid_m = 1'b1; data_m = d; end
    @(posedge clk);
    #1;
    valid_l = 1'b0;
    valid_m = 1'b0;
  endtask

  // Checks every clock of one frame. With inject set, an 0xFF word is pulsed
  // on the MSB instance in the middle of the frame and must be ignored.
  task automatic run_frame(input bit lsb, input logic [NB-1:0] d,
                           input logic exp_par, input bit inject,
                           input string tag);
    int   slot;
    logic e;
    handshake(lsb, d);
    for (int k = 1; k <= FL; k++) begin
      if (k > 1) begin
        @(posedge clk);
        #1;
      end
      slot = (k - 1) / BP;
      if (slot == 0)                      e = 1'b0;
      else if (slot <= NB)                e = lsb ? d[slot-1] : d[NB-slot];
      else if (PB == 1 && slot == NB + 1) e = exp_par;
      else                                e = 1'b1;
      check_eq($sformatf("%s serial clk%0d", tag, k),
               lsb ? so_l : so_m, {31'd0, e});
      check_eq($sformatf("%s done clk%0d", tag, k),
               lsb ? done_l : done_m, {31'd0, k == FL});
      if (k == 1) begin
        check_eq({tag, " busy"},  lsb ? busy_l : busy_m, 32'd1);
        check_eq({tag, " ready"}, lsb ? ready_l : ready_m, 32'd0);
      end
      if (inject && k == 10) begin
        valid_m = 1'b1;
        data_m  = 8'hFF;
      end
      if (inject && k == 11) begin
        check_eq({tag, " ready during pulse"}, ready_m, 32'd0);
        valid_m = 1'b0;
        data_m  = 8'h00;
      end
    end
    @(posedge clk);
    #1;
    check_eq({tag, " idle ready"},  lsb ? ready_l : ready_m, 32'd1);
    check_eq({tag, " idle busy"},   lsb ? busy_l : busy_m, 32'd0);
    check_eq({tag, " idle serial"}, lsb ? so_l : so_m, 32'd1);
    check_eq({tag, " idle done"},   lsb ? done_l : done_m, 32'd0);
  endtask

  initial begin
    n_rst   = 1'b1;
    valid_m = 1'b0;
    valid_l = 1'b0;
    data_m  = '0;
    data_l  = '0;

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("rst serial", so_m,    32'd1);
    check_eq("rst ready",  ready_m, 32'd1);
    check_eq("rst busy",   busy_m,  32'd0);
    check_eq("rst done",   done_m,  32'd0);
    check_eq("rst lsb serial", so_l, 32'd1);
    @(negedge clk);
    n_rst = 1'b1;

    // Handshake on the first rising edge after reset release.
    run_frame(1'b0, 8'hA5, 1'b0, 1'b0, "msb_a5");
    run_frame(1'b0, 8'h07, 1'b1, 1'b0, "msb_07");
    run_frame(1'b1, 8'h01, 1'b1, 1'b0, "lsb_01");
    run_frame(1'b0, 8'h00, 1'b0, 1'b1, "busy_00");

    // Reset during data bit 3 of a 0x3C frame, then resend.
    handshake(1'b0, 8'h3C);
    repeat (17) @(posedge clk);
    #1;
    check_eq("pre_rst busy", busy_m, 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst serial", so_m,    32'd1);
    check_eq("mid_rst busy",   busy_m,  32'd0);
    check_eq("mid_rst ready",  ready_m, 32'd1);
    check_eq("mid_rst done",   done_m,  32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    run_frame(1'b0, 8'h3C, 1'b0, 1'b0, "after_rst_3c");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
